// File: rtl/lms_pkg.sv
// Shared types and default constants for the LMS per-sample sequencer.
package lms_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    DRAIN,
    ERR,
    UPD,
    DONE
  } state_t;

  localparam int DEF_TAPS    = 8;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_MAC_LAT = 2;
  localparam int DEF_OVR_W   = 8;

endpackage

// File: rtl/lms_ovr_monitor.sv
// Sticky overrun flag plus saturating event counter, with a clear that
// outranks a same-cycle event.
module lms_ovr_monitor #(
  parameter int OVR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ovr_event,
  input  logic             ovr_clr,
  output logic             overrun,
  output logic [OVR_W-1:0] ovr_count
);

  localparam logic [OVR_W-1:0] CNT_MAX = {OVR_W{1'b1}};

  // NOTE: registers update with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun   <= 1'b0;
      ovr_count <= '0;
    end else if (ovr_clr) begin
      overrun   <= 1'b0;
      ovr_count <= '0;
    end else if (ovr_event) begin
      overrun <= 1'b1;
      if (ovr_count != CNT_MAX) ovr_count <= ovr_count + 1'b1;
    end
  end

endmodule

// File: rtl/lms_sequencer.sv
// Per-sample controller for the LMS filter: load, MAC sweep, MAC drain,
// error latch and optional weight-update sweep, with overrun detection.
module lms_sequencer
  import lms_pkg::*;
#(
  parameter int TAPS    = DEF_TAPS,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MAC_LAT = DEF_MAC_LAT,
  parameter int OVR_W   = DEF_OVR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              adapt_en,
  input  logic              ovr_clr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] tap_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              err_en,
  output logic              upd_en,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [OVR_W-1:0]  ovr_count
);

  localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [ADDR_W-1:0] TAP_LAST = ADDR_W'(TAPS - 1);
  localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  state_t            state, state_n;
  logic [ADDR_W-1:0] tap_cnt, tap_cnt_n;
  logic [DRN_W-1:0]  drn_cnt, drn_cnt_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      tap_cnt <= '0;
      drn_cnt <= '0;
    end else begin
      state   <= state_n;
      tap_cnt <= tap_cnt_n;
      drn_cnt <= drn_cnt_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    state_n      = state;
    tap_cnt_n    = tap_cnt;
    drn_cnt_n    = drn_cnt;
    sample_ready = 1'b0;
    mem_en       = 1'b0;
    tap_addr     = '0;
    mac_clr      = 1'b0;
    mac_en       = 1'b0;
    err_en       = 1'b0;
    upd_en       = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;

    unique case (state)
      IDLE: begin
        sample_ready = 1'b1;
        busy         = 1'b0;
        if (sample_valid) state_n = LOAD;
      end
      LOAD: begin
        mem_en  = 1'b1;
        state_n = MAC;
      end
      MAC: begin
        mac_en   = 1'b1;
        mac_clr  = (tap_cnt == '0);
        tap_addr = tap_cnt;
        if (tap_cnt == TAP_LAST) begin
          tap_cnt_n = '0;
          state_n   = (MAC_LAT > 0) ? DRAIN : ERR;
        end else begin
          tap_cnt_n = tap_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_cnt == DRN_LAST) begin
          drn_cnt_n = '0;
          state_n   = ERR;
        end else begin
          drn_cnt_n = drn_cnt + 1'b1;
        end
      end
      ERR: begin
        err_en  = 1'b1;
        state_n = adapt_en ? UPD : DONE;
      end
      UPD: begin
        upd_en   = 1'b1;
        tap_addr = tap_cnt;
        if (tap_cnt == TAP_LAST) begin
          tap_cnt_n = '0;
          state_n   = DONE;
        end else begin
          tap_cnt_n = tap_cnt + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  lms_ovr_monitor #(.OVR_W(OVR_W)) u_ovr (
    .clk       (clk),
    .reset     (reset),
    .ovr_event (sample_valid & ~sample_ready),
    .ovr_clr   (ovr_clr),
    .overrun   (overrun),
    .ovr_count (ovr_count)
  );

endmodule

// File: tb/tb_lms_sequencer.sv
// Directed bench for lms_sequencer: cycle-exact phase timing, overrun
// counting/clearing, saturation (second instance with OVR_W=2) and abort.
module tb_lms_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic       adapt_en;
  logic       ovr_clr;

  logic       sample_ready, mem_en, mac_clr, mac_en, err_en, upd_en, busy, done, overrun;
  logic [2:0] tap_addr;
  logic [7:0] ovr_count;

  logic       s_sample_ready, s_mem_en, s_mac_clr, s_mac_en, s_err_en, s_upd_en, s_busy, s_done;
  logic       s_overrun;
  logic [2:0] s_tap_addr;
  logic [1:0] s_ovr_count;

  int checks = 0;
  int errors = 0;
  int sid    = 0;

  always #5 clk = ~clk;

  lms_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .adapt_en     (adapt_en),
    .ovr_clr      (ovr_clr),
    .mem_en       (mem_en),
    .tap_addr     (tap_addr),
    .mac_clr      (mac_clr),
    .mac_en       (mac_en),
    .err_en       (err_en),
    .upd_en       (upd_en),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .ovr_count    (ovr_count)
  );

  lms_sequencer #(.OVR_W(2)) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_ready (s_sample_ready),
    .adapt_en     (adapt_en),
    .ovr_clr      (ovr_clr),
    .mem_en       (s_mem_en),
    .tap_addr     (s_tap_addr),
    .mac_clr      (s_mac_clr),
    .mac_en       (s_mac_en),
    .err_en       (s_err_en),
    .upd_en       (s_upd_en),
    .busy         (s_busy),
    .done         (s_done),
    .overrun      (s_overrun),
    .ovr_count    (s_ovr_count)
  );

  // {ready, busy, mem, clr, mac, err, upd, done, tap[2:0]}
  wire [10:0] obs_vec = {sample_ready, busy, mem_en, mac_clr, mac_en, err_en, upd_en, done, tap_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected control vector in cycle c after acceptance (defaults TAPS=8, MAC_LAT=2).
  function automatic logic [10:0] exp_vec(input int c, input bit adapt);
    logic r, b, m, cl, ma, e, u, d;
    logic [2:0] t;
    int last_busy;
    r = 1'b0; b = 1'b1; m = 1'b0; cl = 1'b0; ma = 1'b0;
    e = 1'b0; u = 1'b0; d = 1'b0; t = 3'd0;
    last_busy = adapt ? 21 : 13;
    if (c > last_busy) begin
      r = 1'b1;
      b = 1'b0;
    end else if (c == 1) begin
      m = 1'b1;
    end else if (c <= 9) begin
      ma = 1'b1;
      cl = (c == 2);
      t  = 3'(c - 2);
    end else if (c <= 11) begin
      b = 1'b1;
    end else if (c == 12) begin
      e = 1'b1;
    end else if (c == last_busy) begin
      d = 1'b1;
    end else begin
      u = 1'b1;
      t = 3'(c - 13);
    end
    return {r, b, m, cl, ma, e, u, d, t};
  endfunction

  // Offer one sample and check every cycle up to the first idle cycle.
  // nov: cycles 1..nov keep sample_valid high (overrun events).
  // abort_at: cycle in which reset is pulled low (0 = none).
  // clr_at: cycle in which ovr_clr is pulsed (0 = none).
  task automatic run_sample(input bit adapt, input int nov, input int abort_at, input int clr_at);
    int last;
    sid++;
    last = adapt ? 22 : 14;
    sample_valid = 1'b1;
    adapt_en     = ~adapt;
    step();
    for (int c = 1; c <= last; c++) begin
      if (abort_at != 0 && c == abort_at + 1) begin
        check($sformatf("s%0d_abort_idle", sid), 32'(obs_vec), 32'(exp_vec(99, adapt)));
        check($sformatf("s%0d_abort_ovr", sid), 32'(ovr_count), 32'd0);
        reset = 1'b1;
        return;
      end
      check($sformatf("s%0d_cyc%0d", sid, c), 32'(obs_vec), 32'(exp_vec(c, adapt)));
      sample_valid = (c <= nov);
      adapt_en     = (c == 12) ? adapt : ~adapt;
      ovr_clr      = (c == clr_at);
      reset        = (c == abort_at) ? 1'b0 : 1'b1;
      if (c < last) step();
    end
    ovr_clr = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    sample_valid = 1'b1;
    adapt_en     = 1'b0;
    ovr_clr      = 1'b0;

    // Reset held with a sample offered: idle outputs, no overrun recorded.
    repeat (3) step();
    check("rst_vec", 32'(obs_vec), 32'(exp_vec(99, 1'b1)));
    check("rst_ovr_count", 32'(ovr_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset        = 1'b1;
    sample_valid = 1'b0;
    step();
    check("post_rst_vec", 32'(obs_vec), 32'(exp_vec(99, 1'b1)));

    // Adapting sample, then non-adapting sample with adapt_en toggled elsewhere.
    run_sample(1'b1, 0, 0, 0);
    run_sample(1'b0, 0, 0, 0);
    check("clean_overrun", 32'(overrun), 32'd0);

    // Five overrun events during a busy sample; timing checked per cycle.
    run_sample(1'b1, 5, 0, 0);
    check("ovr5_flag", 32'(overrun), 32'd1);
    check("ovr5_count", 32'(ovr_count), 32'd5);
    check("ovr5_sat_count", 32'(s_ovr_count), 32'd3);

    // Clear in the same cycle as an event wins.
    run_sample(1'b0, 1, 0, 1);
    check("clr_flag", 32'(overrun), 32'd0);
    check("clr_count", 32'(ovr_count), 32'd0);
    check("clr_sat_count", 32'(s_ovr_count), 32'd0);

    // Six events: wide counter reaches 6, 2-bit counter saturates at 3.
    run_sample(1'b1, 6, 0, 0);
    check("ovr6_count", 32'(ovr_count), 32'd6);
    check("sat_flag", 32'(s_overrun), 32'd1);
    check("sat_count", 32'(s_ovr_count), 32'd3);

    // Reset during the MAC phase, then a sample accepted straight away.
    run_sample(1'b1, 0, 5, 0);
    check("abort_overrun", 32'(overrun), 32'd0);
    run_sample(1'b1, 0, 0, 0);
    check("after_abort_count", 32'(ovr_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lms_sequencer.md
Name: lms_sequencer

Overview:
- Per-sample controller for the LMS adaptive filter datapath.
- On each accepted input sample it sequences four phases:
  - load the sample register (enable of the input-sample holding register);
  - run the MAC filter across all taps;
  - latch the error;
  - optionally sweep the weight-update pass.
- Sits between the ADC/sample source handshake and the data memory, MAC and weight-update blocks.
- Also detects samples that arrive while a computation is still in progress (overrun).

Parameters:
- TAPS, 8, number of filter taps (>=2).
- ADDR_W, 3, tap address width; must satisfy 2**ADDR_W >= TAPS.
- MAC_LAT, 2, pipeline drain cycles of the MAC after the last tap (>=0).
- OVR_W, 8, width of the overrun counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- sample_valid  in  1  source presents a new sample.
- sample_ready  out  1  sequencer can accept a sample.
- adapt_en  in  1  1 = run the weight update for this sample.
- ovr_clr  in  1  clears the overrun flag and counter.
- mem_en  out  1  load enable to the sample/data memory register.
- tap_addr  out  ADDR_W  tap index for the MAC pass and the update pass.
- mac_clr  out  1  clear the accumulator (first MAC tap).
- mac_en  out  1  MAC accumulate strobe.
- err_en  out  1  latch error e = d - y.
- upd_en  out  1  weight-update strobe for tap_addr.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the sample is finished.
- overrun  out  1  sticky flag: a sample was offered while not ready.
- ovr_count  out  OVR_W  saturating count of overrun events.

Behaviour:
- Reset:
  - While reset=0 at a rising edge: state <= IDLE, tap counter <= 0, overrun <= 0, ovr_count <= 0.
  - Reset mid-operation aborts immediately; no done pulse is issued.
- Outputs:
  - All control outputs are Moore outputs, decoded from the registered state and tap counter.
  - In IDLE (including during reset): sample_ready=1, tap_addr=0, all strobes 0, busy=0.
- Handshake:
  - A sample is accepted at the edge where sample_valid & sample_ready.
  - sample_ready is high only in IDLE.
- States and transitions, cycles counted after the acceptance edge (cycle 1 is the first cycle after it):
  - IDLE: on accept -> LOAD.
  - LOAD, 1 cycle: mem_en=1 -> MAC.
  - MAC, TAPS cycles: mac_en=1; tap_addr = 0..TAPS-1 incrementing; mac_clr=1 only when tap_addr=0.
    - On the last tap -> DRAIN if MAC_LAT>0, else -> ERR.
  - DRAIN, MAC_LAT cycles: all strobes 0 -> ERR.
  - ERR, 1 cycle: err_en=1. adapt_en is sampled at the end of this cycle.
    - adapt_en=1 -> UPD; adapt_en=0 -> DONE.
  - UPD, TAPS cycles: upd_en=1; tap_addr = 0..TAPS-1 -> DONE.
  - DONE, 1 cycle: done=1 -> IDLE.
- Latency with defaults (TAPS=8, MAC_LAT=2):
  - Adapting: done in cycle 21; sample_ready high again in cycle 22.
  - Non-adapting: done in cycle 13.
  - General (adapting): done in cycle 1 + TAPS + MAC_LAT + 1 + TAPS + 1.
- Tap counter:
  - Counts 0..TAPS-1, then returns to 0 on each phase exit.
  - It never wraps inside a phase.
  - tap_addr=0 outside the MAC and UPD states.
- Overrun:
  - Overrun event = sample_valid=1 at an edge where sample_ready=0.
  - On an event: overrun <= 1; ovr_count increments, saturating at 2**OVR_W-1.
  - The offered sample is dropped; the sequence in progress is unaffected.
  - ovr_clr has priority over a same-cycle event: flag and count both go to 0.
- Timing of sample_valid:
  - sample_valid held high through DONE is not accepted until IDLE.
  - Each non-ready cycle in which sample_valid is high counts as a separate event.
- adapt_en changes outside the ERR cycle have no effect.

Decomposition:
- Package lms_pkg holds:
  - the state enum (IDLE, LOAD, MAC, DRAIN, ERR, UPD, DONE);
  - the default TAPS, ADDR_W and MAC_LAT constants.
- One natural sub-module: lms_ovr_monitor, containing the overrun flag, the saturating counter and the clear logic.
- The FSM and tap counter stay in lms_sequencer.

Test Plan:
- Reset: hold reset=0 for 3 cycles with sample_valid=1 -> sample_ready=1, busy=0, all strobes 0, ovr_count=0.
- Single adapting sample, adapt_en=1, defaults:
  - mem_en in cycle 1;
  - mac_en cycles 2-9 with tap_addr 0..7 and mac_clr only in cycle 2;
  - err_en cycle 12;
  - upd_en cycles 13-20 with tap_addr 0..7;
  - done cycle 21;
  - sample_ready in cycle 22.
- Non-adapting sample: adapt_en=0 in cycle 12 -> no upd_en, done in cycle 13; then adapt_en=1 mid-DONE -> ignored.
- Overrun:
  - sample_valid high for 5 busy cycles -> overrun=1, ovr_count=5, sequence timing unchanged.
  - ovr_clr together with an event -> ovr_count=0.
- Saturation: OVR_W=2, 6 overrun events -> ovr_count=3.
- Reset mid-operation: reset=0 in cycle 5 (MAC phase) -> next cycle IDLE, mac_en=0, no done pulse; a new sample is accepted right after reset=1.
